// File: rtl/hidden_neuron.sv
// Hidden-layer neuron: unsigned features times signed Q1.7 weights, summed, then ReLU, /128 and clamp to 10 bits.
// Optional bias input is compiled in with the HIDDEN_BIAS_EN macro.
module hidden_neuron #(
  parameter int N_INPUTS = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [7:0]  x_i,
  input  logic [7:0]  w_i,
`ifdef HIDDEN_BIAS_EN
  input  logic [15:0] bias_i,
`endif
  output logic [9:0]  act_o,
  output logic        act_valid_o,
  input  logic        act_ready_i,
  output logic        busy_o
);

  localparam int CNT_W = $clog2(N_INPUTS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, ACT, HOLD} state_t;

  state_t             state_q, state_d;
  logic [21:0]        acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [9:0]         act_q, act_d;

  logic [15:0]        biasTerm;
  logic signed [16:0] xExt, wExt, prod;
  logic signed [22:0] sumS, shrS;
  logic               accept;

`ifdef HIDDEN_BIAS_EN
  assign biasTerm = bias_i;
`else
  assign biasTerm = 16'd0;
`endif

  // 17-bit operands keep the product exact; the low 17 bits of the full product are the true result
  assign xExt   = {9'd0, x_i};
  assign wExt   = {{9{w_i[7]}}, w_i};
  assign prod   = xExt * wExt;
  assign accept = (state_q == ACCUM) && in_valid_i;

  assign sumS = {acc_q[21], acc_q} + {{7{biasTerm[15]}}, biasTerm};
  assign shrS = sumS >>> 7;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d = acc_q + {{5{prod[16]}}, prod};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) state_d = ACT;
        end
      end
      ACT: begin
        if (shrS[22])          act_d = 10'd0;
        else if (|shrS[21:10]) act_d = 10'd1023;
        else                   act_d = shrS[9:0];
        state_d = HOLD;
      end
      HOLD: begin
        if (act_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      act_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
    end
  end

  assign act_o       = act_q;
  assign act_valid_o = (state_q == HOLD);
  assign in_ready_o  = (state_q == ACCUM);
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_hidden_neuron.sv
// Directed-vector bench for hidden_neuron; bias vectors run only when HIDDEN_BIAS_EN is defined.
module tb_hidden_neuron;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        start = 1'b0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [7:0]  x = '0;
  logic [7:0]  w = '0;
  logic [15:0] bias = '0;
  logic [9:0]  act;
  logic        actValid;
  logic        actReady = 1'b0;
  logic        busy;

  int testsRun = 0;
  int testsFailed = 0;

  hidden_neuron #(.N_INPUTS(4)) dut (
    .clk_i       (clk),
    .rst_i       (rstN),
    .start_i     (start),
    .in_valid_i  (inValid),
    .in_ready_o  (inReady),
    .x_i         (x),
    .w_i         (w),
`ifdef HIDDEN_BIAS_EN
    .bias_i      (bias),
`endif
    .act_o       (act),
    .act_valid_o (actValid),
    .act_ready_i (actReady),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic doStart();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] xv, input logic [7:0] wv);
    x       = xv;
    w       = wv;
    inValid = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
  endtask

  task automatic handshake(input string tag);
    actReady = 1'b1;
    @(negedge clk);
    actReady = 1'b0;
    checkOutput({tag, "_busy_after"}, int'(busy), 0);
    checkOutput({tag, "_valid_after"}, int'(actValid), 0);
  endtask

  // Byte i of xs/ws is pair i; result appears exactly two edges after the last pair
  task automatic runVector(input string tag, input logic [31:0] xs, input logic [31:0] ws,
                           input logic [15:0] b, input int expAct);
    doStart();
    bias = b;
    for (int i = 0; i < 4; i++) applyStimulus(xs[8*i +: 8], ws[8*i +: 8]);
    checkOutput({tag, "_valid_early"}, int'(actValid), 0);
    @(negedge clk);
    checkOutput({tag, "_valid"}, int'(actValid), 1);
    checkOutput({tag, "_act"}, int'(act), expAct);
    handshake(tag);
  endtask

  initial begin
    @(negedge clk);
    #1;
    checkOutput("rst_act", int'(act), 0);
    checkOutput("rst_valid", int'(actValid), 0);
    checkOutput("rst_ready", int'(inReady), 0);
    checkOutput("rst_busy", int'(busy), 0);
    @(negedge clk);
    rstN = 1'b1;

    doStart();
    checkOutput("start_ready", int'(inReady), 1);
    checkOutput("start_busy", int'(busy), 1);
    for (int i = 0; i < 4; i++) applyStimulus(8'(10 * (i + 1)), 8'h40);
    @(negedge clk);
    checkOutput("pos_valid", int'(actValid), 1);
    checkOutput("pos_act", int'(act), 50);
    handshake("pos");

    runVector("relu", {8'd40, 8'd30, 8'd20, 8'd10}, {4{8'hC0}}, 16'd0, 0);
    runVector("mixed", {8'd128, 8'd0, 8'd50, 8'd200}, {8'h01, 8'h55, 8'h80, 8'h7F}, 16'd0, 149);
    runVector("negsmall", {8'd0, 8'd0, 8'd0, 8'd1}, {8'h00, 8'h00, 8'h00, 8'hFF}, 16'd0, 0);
    runVector("floor", {8'd0, 8'd0, 8'd0, 8'd3}, {8'h00, 8'h00, 8'h00, 8'h40}, 16'd0, 1);
    runVector("max", {4{8'd255}}, {4{8'h7F}}, 16'd0, 1012);
`ifdef HIDDEN_BIAS_EN
    runVector("bias_sat", {4{8'd255}}, {4{8'h7F}}, 16'h7FFF, 1023);
    runVector("bias_neg", {8'd40, 8'd30, 8'd20, 8'd10}, {4{8'h40}}, 16'hFF80, 49);
`endif

    // Stall between pairs 2 and 3 with stray start pulses in ACCUM and HOLD
    doStart();
    applyStimulus(8'd10, 8'h40);
    applyStimulus(8'd20, 8'h40);
    for (int i = 0; i < 3; i++) begin
      start = (i == 1);
      @(negedge clk);
      checkOutput($sformatf("stall_ready%0d", i), int'(inReady), 1);
    end
    start = 1'b0;
    applyStimulus(8'd30, 8'h40);
    applyStimulus(8'd40, 8'h40);
    checkOutput("stall_valid_early", int'(actValid), 0);
    @(negedge clk);
    checkOutput("stall_act", int'(act), 50);
    start    = 1'b1;
    actReady = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    actReady = 1'b0;
    checkOutput("hold_start_busy", int'(busy), 0);
    @(negedge clk);
    checkOutput("hold_start_still_idle", int'(busy), 0);

    // Downstream back-pressure in HOLD
    doStart();
    for (int i = 0; i < 4; i++) applyStimulus(8'(10 * (i + 1)), 8'h40);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("bp_act%0d", i), int'(act), 50);
      checkOutput($sformatf("bp_valid%0d", i), int'(actValid), 1);
    end
    handshake("bp");
    checkOutput("bp_act_retained", int'(act), 50);

    // Asynchronous reset mid-accumulation, then a clean run
    doStart();
    applyStimulus(8'd200, 8'h7F);
    applyStimulus(8'd200, 8'h7F);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("arst_act", int'(act), 0);
    checkOutput("arst_busy", int'(busy), 0);
    checkOutput("arst_ready", int'(inReady), 0);
    checkOutput("arst_valid", int'(actValid), 0);
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(8'd10, 8'h40);
    checkOutput("arst_no_auto_start", int'(busy), 0);
    runVector("arst_rerun", {8'd40, 8'd30, 8'd20, 8'd10}, {4{8'h40}}, 16'd0, 50);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/hidden_neuron.md
HIDDEN_NEURON -- requirements
Module: hidden_neuron

Interface
REQ-001 SHALL have parameter N_INPUTS, default 4, legal range 1..16: number of input/weight pairs accumulated per activation.
REQ-002 SHALL have port clk_i, input, 1 bit: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start_i, input, 1 bit: begin a new activation; honoured only in IDLE.
REQ-005 SHALL have port in_valid_i, input, 1 bit: x_i/w_i pair valid this cycle.
REQ-006 SHALL have port in_ready_o, output, 1 bit: block accepts a pair this cycle.
REQ-007 SHALL have port x_i, input, 8 bits: unsigned integer feature.
REQ-008 SHALL have port w_i, input, 8 bits: signed two's-complement weight, Q1.7.
REQ-009 SHALL have port bias_i, input, 16 bits: signed bias in units of 2^-7; present only when HIDDEN_BIAS_EN is defined.
REQ-010 SHALL have port act_o, output, 10 bits: unsigned activation, feeds the output neuron x inputs.
REQ-011 SHALL have port act_valid_o, output, 1 bit: act_o holds a completed activation.
REQ-012 SHALL have port act_ready_i, input, 1 bit: downstream consumes act_o.
REQ-013 SHALL have port busy_o, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, ACCUM, ACT and HOLD.
REQ-015 IDLE: start_i=1 SHALL clear the accumulator and the pair counter and move to ACCUM on the next edge; start_i SHALL be ignored in all other states.
REQ-016 in_ready_o SHALL be 1 exactly when the state is ACCUM.
REQ-017 ACCUM: a pair SHALL be accepted only on a cycle with in_valid_i=1 and in_ready_o=1; acc += signed(x_i zero-extended) * signed(w_i); counter +1.
REQ-018 ACCUM: a cycle with in_valid_i=0 SHALL leave the accumulator and counter unchanged (stall, no timeout).
REQ-019 Acceptance of pair number N_INPUTS SHALL move the state to ACT on the same edge.
REQ-020 The accumulator SHALL be 22-bit signed, and products SHALL be 17-bit signed; overflow SHALL be impossible over the legal N_INPUTS range.
REQ-021 ACT (exactly one cycle): s = acc + bias (sign-extended) when the bias feature is compiled in, else s = acc; r = s arithmetically shifted right by 7 (floor).
REQ-022 ACT: act_o SHALL be registered as 0 if r<0, 1023 if r>1023, otherwise r[9:0]; the state then moves to HOLD.
REQ-023 HOLD: act_valid_o=1 and act_o SHALL be held stable until act_ready_i=1; on that edge the state moves to IDLE and act_valid_o returns to 0.
REQ-024 act_valid_o SHALL be 0 in every state except HOLD.
REQ-025 act_o SHALL retain its last value after leaving HOLD, until the next ACT overwrites it.
REQ-026 Latency from the final accepted pair to act_valid_o=1 SHALL be 2 edges.
REQ-027 A start_i asserted together with act_ready_i in HOLD SHALL be ignored; a new start is required in IDLE.
REQ-028 bias_i SHALL be sampled in ACT only.

Reset
REQ-029 rst_i=0 SHALL immediately, without waiting for a clock edge, force state IDLE, accumulator 0, counter 0, act_o=0, act_valid_o=0, in_ready_o=0, busy_o=0.
REQ-030 Reset asserted in any state, including mid-accumulation, SHALL discard the partial sum; operation SHALL resume only on a new start_i after reset release.

Configuration
REQ-031 With macro HIDDEN_BIAS_EN defined, the bias_i port SHALL exist and be added in ACT per REQ-021.
REQ-032 Without HIDDEN_BIAS_EN, there SHALL be no bias_i port and the bias term SHALL be 0; all other behaviour SHALL be identical.

Verification
REQ-033 N_INPUTS=4, no bias: start; x=10,20,30,40 each with w=0x40 on consecutive cycles -> act_o=50 with act_valid_o=1 two edges after the 4th pair.
REQ-034 Same x values with w=0xC0 -> act_o=0 (ReLU clamp).
REQ-035 HIDDEN_BIAS_EN, x=255 and w=0x7F for all 4 pairs, bias=0x7FFF -> act_o=1023 (saturation); with bias=0 -> act_o=1012.
REQ-036 in_valid_i deasserted for 3 cycles between pairs 2 and 3 -> result unchanged, 3 extra cycles of latency; start_i pulses during ACCUM/HOLD ignored.
REQ-037 act_ready_i held low 5 cycles in HOLD -> act_o and act_valid_o stable; act_ready_i=1 -> IDLE next edge, busy_o=0.
REQ-038 rst_i pulsed low after pair 2 -> all outputs 0 immediately; a new start with 4 pairs yields the correct result without residue.
